// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: FSM state type,
// default geometry and the digit-counter width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  // Counter needs clog2(n) bits to count 0..n-1, but never fewer than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple of full adders. Besides the sum and the
// carry out of the top bit it exposes the carry into the top bit, which the
// caller needs for signed-overflow detection on the most significant digit.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // Ripple the carry through DIGIT full adders.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT - 1];

endmodule

// File: rtl/serial_adder_n_bit.sv
// Digit-serial WIDTH-bit add/subtract unit with start/busy/done handshake.
// DIGIT bits are summed per clock, least-significant digit first, so a
// result appears NDIG = WIDTH/DIGIT clocks after an accepted start.
// Optional build macro ADDSUB_SAT_EN: saturate S to signed max/min on
// overflow instead of wrapping (Cout/Ovf are reported unchanged).
module serial_adder_n_bit
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_geometry
      $error("serial_adder_n_bit: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   acc;
  logic               carry;

  logic [DIGIT-1:0]   dsum;
  logic               dcout;
  logic               dcmsb;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   s_final;
  logic               last_digit;
  logic               ovf_now;

`ifdef ADDSUB_SAT_EN
  // Signed max for a non-negative overflow, signed min for a negative one.
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    logic [WIDTH-1:0] smin;
    smin            = '0;
    smin[WIDTH-1]   = 1'b1;
    return neg ? smin : ~smin;
  endfunction
`endif

  // Operand registers shift right each RUN cycle, so the current digit
  // always sits in the low DIGIT bits.
  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .sum   (dsum),
    .cout  (dcout),
    .c_msb (dcmsb)
  );

  // New digit enters at the top of the accumulator; after NDIG shifts the
  // first digit has reached bit 0. Written as shifts so NDIG=1 needs no
  // zero-width slice.
  always_comb begin
    acc_next   = (acc >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    last_digit = (cnt == CNT_W'(NDIG - 1));
    ovf_now    = dcmsb ^ dcout;
`ifdef ADDSUB_SAT_EN
    // On the last digit a_sh[DIGIT-1] is the sign bit of A; with an
    // overflow both effective operands share that sign.
    s_final    = ovf_now ? sat_value(a_sh[DIGIT-1]) : acc_next;
`else
    s_final    = acc_next;
`endif
  end

  // Control FSM plus datapath registers; outputs are registered and only
  // updated on completion, so partial sums never reach S.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_sh  <= Sub ? ~B : B;
            carry <= Cin ^ Sub;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          acc   <= acc_next;
          carry <= dcout;
          if (last_digit) begin
            S     <= s_final;
            Cout  <= dcout;
            Ovf   <= ovf_now;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n_bit.sv
// Self-checking bench for serial_adder_n_bit: a 16/4 instance for the main
// sequence and a 4/4 instance for the single-digit case. Expected values come
// from plain integer arithmetic on the operands.
module tb_serial_adder_n_bit;

  localparam int NDIG16 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        Cin = 1'b0, Sub = 1'b0;
  logic        busy, done, Cout, Ovf;
  logic [15:0] S;

  logic        s_start = 1'b0;
  logic [3:0]  s_A = '0, s_B = '0;
  logic        s_Cin = 1'b0, s_Sub = 1'b0;
  logic        s_busy, s_done, s_Cout, s_Ovf;
  logic [3:0]  s_S;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder_n_bit #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .Ovf(Ovf)
  );

  serial_adder_n_bit #(.WIDTH(4), .DIGIT(4)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .A(s_A), .B(s_B), .Cin(s_Cin), .Sub(s_Sub),
    .busy(s_busy), .done(s_done), .S(s_S), .Cout(s_Cout), .Ovf(s_Ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, s} from integer arithmetic.
  function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] be;
    logic [16:0] f;
    logic [15:0] s;
    logic        ov;
    be = sub ? ~b : b;
    f  = {1'b0, a} + {1'b0, be} + 17'(cin ^ sub);
    s  = f[15:0];
    ov = (a[15] == be[15]) && (s[15] != a[15]);
`ifdef ADDSUB_SAT_EN
    if (ov) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {ov, f[16], s};
  endfunction

  function automatic logic [5:0] ref4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin, input logic sub);
    logic [3:0] be;
    logic [4:0] f;
    logic [3:0] s;
    logic       ov;
    be = sub ? ~b : b;
    f  = {1'b0, a} + {1'b0, be} + 5'(cin ^ sub);
    s  = f[3:0];
    ov = (a[3] == be[3]) && (s[3] != a[3]);
`ifdef ADDSUB_SAT_EN
    if (ov) s = a[3] ? 4'h8 : 4'h7;
`endif
    return {ov, f[4], s};
  endfunction

  // Wait (bounded) at negedges for done on the 16-bit DUT; returns negedges waited and busy count.
  task automatic wait_done16(input string tag, output int n, output int nb);
    n  = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic chk_res16(input string tag, input logic [17:0] e);
    chk({tag, "_S"},    32'(S),    32'(e[15:0]));
    chk({tag, "_Cout"}, 32'(Cout), 32'(e[16]));
    chk({tag, "_Ovf"},  32'(Ovf),  32'(e[17]));
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub);
    int n, nb;
    @(negedge clk);
    A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done16(tag, n, nb);
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(NDIG16));
    chk({tag, "_latency"}, 32'(n), 32'(NDIG16));
    chk_res16(tag, ref16(a, b, cin, sub));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic cin, input logic sub);
    logic [5:0] e;
    e = ref4(a, b, cin, sub);
    @(negedge clk);
    s_A = a; s_B = b; s_Cin = cin; s_Sub = sub; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk({tag, "_busy"}, 32'(s_busy), 32'd1);
    chk({tag, "_done_early"}, 32'(s_done), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(s_done), 32'd1);
    chk({tag, "_busy_off"}, 32'(s_busy), 32'd0);
    chk({tag, "_S"}, 32'(s_S), 32'(e[3:0]));
    chk({tag, "_Cout"}, 32'(s_Cout), 32'(e[4]));
    chk({tag, "_Ovf"}, 32'(s_Ovf), 32'(e[5]));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(s_done), 32'd0);
  endtask

  initial begin
    int n, nb, pulses;
    logic [15:0] ra, rb;
    logic        rc, rs;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_Cout", 32'(Cout), 32'd0);
    chk("rst_Ovf", 32'(Ovf), 32'd0);
    chk("rst_small_S", 32'(s_S), 32'd0);
    rst_n = 1'b1;

    // Single-digit unit
    op4("t1", 4'b1010, 4'b0101, 1'b0, 1'b0);
    op4("t1_ovf", 4'h7, 4'h1, 1'b0, 1'b0);
    op4("t1_sub", 4'h2, 4'h5, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      op4("t1_rnd", 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

    // Carry wrap, subtract, overflow
    op16("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op16("t3a", 16'h0005, 16'h0007, 1'b0, 1'b1);
    op16("t3b", 16'h0005, 16'h0007, 1'b1, 1'b1);
    op16("t4a", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op16("t4b", 16'h8000, 16'hFFFF, 1'b0, 1'b0);
    op16("t4c", 16'h8000, 16'h0001, 1'b0, 1'b1);

    // Start during RUN is ignored
    @(negedge clk);
    A = 16'h1234; B = 16'h4321; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'hF0F0; B = 16'h0F0F; Sub = 1'b1; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'hAAAA;
    wait_done16("t5_ign", n, nb);
    chk_res16("t5_ign", ref16(16'h1234, 16'h4321, 1'b0, 1'b0));
    @(negedge clk);
    chk("t5_ign_idle_busy", 32'(busy), 32'd0);

    // Back-to-back: start held in the DONE cycle
    @(negedge clk);
    A = 16'h00FF; B = 16'h0F01; Cin = 1'b1; Sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done16("t5_b2b1", n, nb);
    chk_res16("t5_b2b1", ref16(16'h00FF, 16'h0F01, 1'b1, 1'b0));
    A = 16'h9000; B = 16'h2000; Cin = 1'b0; Sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_b2b_busy", 32'(busy), 32'd1);
    chk("t5_b2b_hold_S", 32'(S), 32'(16'h00FF + 16'h0F01 + 16'h0001));
    wait_done16("t5_b2b2", n, nb);
    chk("t5_b2b_gap", 32'(n + 1), 32'(NDIG16 + 1));
    chk_res16("t5_b2b2", ref16(16'h9000, 16'h2000, 1'b0, 1'b1));
    @(negedge clk);

    // Reset mid-operation; leave nonzero outputs first
    op16("t6_pre", 16'h8000, 16'hFFFF, 1'b0, 1'b0);
    @(negedge clk);
    A = 16'h0101; B = 16'h0202; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_S", 32'(S), 32'd0);
    chk("t6_Cout", 32'(Cout), 32'd0);
    chk("t6_Ovf", 32'(Ovf), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("t6_no_done", 32'(pulses), 32'd0);
    op16("t6_after", 16'h0101, 16'h0202, 1'b0, 1'b0);

    // Randomised operations against the model
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      op16("rnd", ra, rb, rc, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
